countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Two-digit BCD down-counter (00-99) with an IDLE/RUN/DONE state machine.
//   clk   : single clock, all state changes on the rising edge
//   mr    : asynchronous active-low master reset
//   load  : synchronous active-low preset load (wins over everything but mr)
//   en    : count enable, active-high (low pauses the count while running)
//   d     : BCD preset, d[7:4] tens, d[3:0] ones; digits above 9 clamp to 9
//   q     : registered BCD count
//   bo    : registered borrow-out, high for the cycle in which q becomes 00
//   busy  : registered, high while in RUN
//   done  : registered, high while in DONE
// AUTO_RELOAD=1 turns the 00 terminal count into a reload of the stored preset.
module countdown_timer #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       clk,
   input  logic       mr,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] d,
   output logic [7:0] q,
   output logic       bo,
   output logic       busy,
   output logic       done
);

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned COUNT_W = 2 * DIGIT_W;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
   localparam logic [COUNT_W-1:0] COUNT_ZERO = COUNT_W'(0);
   localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [COUNT_W-1:0]   preset;
   logic [COUNT_W-1:0]   preset_nxt;
   logic [COUNT_W-1:0]   q_nxt;
   logic                 bo_nxt;
   logic                 busy_nxt;
   logic                 done_nxt;
   logic [COUNT_W-1:0]   d_clamped;
   logic [COUNT_W-1:0]   q_dec;

   // Saturate one BCD digit at 9.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] x);
      return (x > DIGIT_MAX) ? DIGIT_MAX : x;
   endfunction

   // Clamped preset and BCD decrement of the current count.
   always_comb begin
      d_clamped = {clamp_digit(d[COUNT_W-1:DIGIT_W]), clamp_digit(d[DIGIT_W-1:0])};
      if (q[DIGIT_W-1:0] == DIGIT_W'(0)) begin
         q_dec = {q[COUNT_W-1:DIGIT_W] - DIGIT_W'(1), DIGIT_MAX};
      end else begin
         q_dec = {q[COUNT_W-1:DIGIT_W], q[DIGIT_W-1:0] - DIGIT_W'(1)};
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt  = state;
      q_nxt      = q;
      preset_nxt = preset;
      bo_nxt     = 1'b0;

      if (!load) begin
         q_nxt      = d_clamped;
         preset_nxt = d_clamped;
         state_nxt  = (d_clamped != COUNT_ZERO) ? S_RUN : S_DONE;
      end else begin
         case (state)
            S_RUN: begin
               if (en) begin
                  if (q == COUNT_ZERO) begin
                     // Only reachable with auto-reload: the cycle after the wrap.
                     q_nxt = preset;
                  end else begin
                     q_nxt = q_dec;
                     if (q == COUNT_ONE) begin
                        bo_nxt = 1'b1;
                        if (!AUTO_RELOAD) begin
                           state_nxt = S_DONE;
                        end
                     end
                  end
               end
            end
            default: begin
               // IDLE and DONE ignore en; only a load leaves them.
            end
         endcase
      end

      busy_nxt = (state_nxt == S_RUN);
      done_nxt = (state_nxt == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         state  <= S_IDLE;
         preset <= COUNT_ZERO;
         q      <= COUNT_ZERO;
         bo     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         preset <= preset_nxt;
         q      <= q_nxt;
         bo     <= bo_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

endmodule
